// File: rtl/pq_arb.sv
// pq_arb: round-robin enqueue arbiter and dequeue/flush sequencer placed in
// front of an external priority queue. The queue itself lives outside; this
// block drives its command pins and tracks occupancy.

package pq_pkg;
  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;
endpackage

// state | meaning
// RUN   | normal operation: grants enqueues, services dequeue requests
// FLUSH | drains the queue one entry per cycle, discarding the data
module pq_arb #(
  parameter int NREQ      = 4,
  parameter int DEPTH     = 8,
  parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
  parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
  localparam int KVW      = KEY_WIDTH + VAL_WIDTH,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0][KVW-1:0]  req_kv,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      deq_req,
  output logic                      deq_ready,
  output logic                      deq_valid,
  output logic [KVW-1:0]            deq_kv,
  input  logic                      flush,
  output logic                      flush_done,
  output logic [CW-1:0]             count,
  output logic                      pq_rst,
  output logic                      pq_enq,
  output logic                      pq_deq,
  output logic [KVW-1:0]            pq_kvi,
  input  logic [KVW-1:0]            pq_kvo,
  input  logic                      pq_empty,
  input  logic                      pq_full
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            deq_pend_q, deq_pend_d;
  logic            deq_valid_q, deq_valid_d;
  logic [KVW-1:0]  deq_kv_q, deq_kv_d;
  logic            flush_done_q, flush_done_d;

  logic            run;
  logic            issue;
  logic            elig;
  logic            found;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt;

  // Round-robin search from rr_ptr; the grant is only asserted when an enqueue is allowed.
  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        found   = 1'b1;
        gnt_idx = PW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
    if (found && elig) gnt[gnt_idx] = 1'b1;
  end

  // Dequeue issue, enqueue eligibility, queue commands and next-state logic.
  always_comb begin
    run   = rst && (state_q == RUN);
    // deq_pend already implies a request that was accepted earlier; a fresh
    // request is only taken while deq_ready is high.
    issue = run && (deq_pend_q || (deq_req && !deq_pend_q)) && !pq_empty;
    // A full queue can still take an entry when a dequeue frees a slot this cycle.
    elig  = run && (!pq_full || issue);

    pq_rst = !rst;
    pq_enq = |gnt;
    pq_deq = issue || (rst && (state_q == FLUSH) && !pq_empty);
    pq_kvi = (|gnt) ? req_kv[gnt_idx] : '0;

    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    count_d      = count_q;
    deq_pend_d   = deq_pend_q;
    deq_valid_d  = issue;
    deq_kv_d     = issue ? pq_kvo : deq_kv_q;
    flush_done_d = 1'b0;

    if (|gnt) rr_ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);

    unique case ({pq_enq, pq_deq})
      2'b10:   count_d = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
      2'b01:   count_d = (count_q == '0) ? count_q : count_q - CW'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      RUN: begin
        if (run && deq_req && !deq_pend_q && pq_empty) deq_pend_d = 1'b1;
        if (issue) deq_pend_d = 1'b0;
        if (flush) begin
          state_d    = FLUSH;
          deq_pend_d = 1'b0;
        end
      end
      FLUSH: begin
        if (pq_empty) begin
          flush_done_d = 1'b1;
          state_d      = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RUN;
      rr_ptr_q     <= '0;
      count_q      <= '0;
      deq_pend_q   <= 1'b0;
      deq_valid_q  <= 1'b0;
      deq_kv_q     <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      count_q      <= count_d;
      deq_pend_q   <= deq_pend_d;
      deq_valid_q  <= deq_valid_d;
      deq_kv_q     <= deq_kv_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign req_ready  = gnt;
  assign deq_ready  = !deq_pend_q;
  assign deq_valid  = deq_valid_q;
  assign deq_kv     = deq_kv_q;
  assign flush_done = flush_done_q;
  assign count      = count_q;

endmodule

// File: tb/tb_pq_arb.sv
// tb_pq_arb: directed vector table plus hand sequences for pq_arb, with a
// small behavioural priority queue (largest key first, FIFO among equal keys).

module tb_pq_arb;

  localparam int NREQ = 4;
  localparam int DEPTH = 4;
  localparam int KW = 4;
  localparam int VW = 4;
  localparam int KVW = KW + VW;
  localparam int CW = 3;

  logic                     clk;
  logic                     rst;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0][KVW-1:0] req_kv;
  logic [NREQ-1:0]          req_ready;
  logic                     deq_req;
  logic                     deq_ready;
  logic                     deq_valid;
  logic [KVW-1:0]           deq_kv;
  logic                     flush;
  logic                     flush_done;
  logic [CW-1:0]            count;
  logic                     pq_rst;
  logic                     pq_enq;
  logic                     pq_deq;
  logic [KVW-1:0]           pq_kvi;
  logic [KVW-1:0]           pq_kvo;
  logic                     pq_empty;
  logic                     pq_full;

  pq_arb #(.NREQ(NREQ), .DEPTH(DEPTH), .KEY_WIDTH(KW), .VAL_WIDTH(VW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_kv(req_kv),
    .req_ready(req_ready), .deq_req(deq_req), .deq_ready(deq_ready),
    .deq_valid(deq_valid), .deq_kv(deq_kv), .flush(flush),
    .flush_done(flush_done), .count(count), .pq_rst(pq_rst),
    .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi), .pq_kvo(pq_kvo),
    .pq_empty(pq_empty), .pq_full(pq_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural priority queue, kept sorted with the head at index 0.
  logic [KVW-1:0] q_mem [DEPTH];
  int             q_cnt = 0;
  logic [KVW-1:0] m_tmp [DEPTH];
  int             m_c;
  int             m_pos;

  assign pq_empty = (q_cnt == 0);
  assign pq_full  = (q_cnt == DEPTH);
  assign pq_kvo   = (q_cnt > 0) ? q_mem[0] : '0;

  always @(posedge clk) begin
    if (pq_rst) begin
      q_cnt <= 0;
    end else begin
      m_tmp = q_mem;
      m_c   = q_cnt;
      if (pq_deq && m_c > 0) begin
        for (int j = 0; j < DEPTH - 1; j++) m_tmp[j] = m_tmp[j+1];
        m_c = m_c - 1;
      end
      if (pq_enq && m_c < DEPTH) begin
        m_pos = m_c;
        for (int j = m_c - 1; j >= 0; j--)
          if (pq_kvi[KVW-1:VW] > m_tmp[j][KVW-1:VW]) m_pos = j;
        for (int j = DEPTH - 1; j > 0; j--)
          if (j > m_pos) m_tmp[j] = m_tmp[j-1];
        m_tmp[m_pos] = pq_kvi;
        m_c = m_c + 1;
      end
      q_mem <= m_tmp;
      q_cnt <= m_c;
    end
  end

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [31:0] kv;
    logic        dq;
    logic        fl;
    logic [3:0]  e_rdy;
    logic        e_enq;
    logic        e_deq;
    logic [2:0]  e_cnt;
    logic        e_dv;
    logic [7:0]  e_dkv;
    logic        e_fd;
    logic        e_drdy;
  } vec_t;

  vec_t vq[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic add(input logic r, input logic [3:0] rv, input logic [31:0] kv,
                     input logic dq, input logic fl, input logic [3:0] rdy,
                     input logic enq, input logic deq, input logic [2:0] cnt,
                     input logic dv, input logic [7:0] dkv, input logic fd,
                     input logic drdy);
    vec_t v;
    v = '{r, rv, kv, dq, fl, rdy, enq, deq, cnt, dv, dkv, fd, drdy};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic [3:0] rv, input logic [31:0] kv,
                       input logic dq, input logic fl);
    rst       = r;
    req_valid = rv;
    req_kv    = kv;
    deq_req   = dq;
    flush     = fl;
  endtask

  initial begin
    drive(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);

    // Scenario 1: reset, then four requesters granted in rotation until full.
    add(0, 4'hF, 32'h14437221, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, 0, 1);
    add(1, 4'hF, 32'h14437221, 0, 0, 4'h1, 1, 0, 1, 0, 8'h00, 0, 1);
    add(1, 4'hF, 32'h14437221, 0, 0, 4'h2, 1, 0, 2, 0, 8'h00, 0, 1);
    add(1, 4'hF, 32'h14437221, 0, 0, 4'h4, 1, 0, 3, 0, 8'h00, 0, 1);
    add(1, 4'hF, 32'h14437221, 0, 0, 4'h8, 1, 0, 4, 0, 8'h00, 0, 1);
    add(1, 4'hF, 32'h14437221, 0, 0, 4'h0, 0, 0, 4, 0, 8'h00, 0, 1);
    // Scenario 3: full queue, enqueue (1,11) alongside a dequeue.
    add(1, 4'h2, 32'h00001B00, 1, 0, 4'h2, 1, 1, 4, 1, 8'h72, 0, 1);
    add(1, 4'h0, 32'h0,        1, 0, 4'h0, 0, 1, 3, 1, 8'h43, 0, 1);
    add(1, 4'h0, 32'h0,        1, 0, 4'h0, 0, 1, 2, 1, 8'h21, 0, 1);
    add(1, 4'h0, 32'h0,        1, 0, 4'h0, 0, 1, 1, 1, 8'h14, 0, 1);
    add(1, 4'h0, 32'h0,        1, 0, 4'h0, 0, 1, 0, 1, 8'h1B, 0, 1);
    add(1, 4'h0, 32'h0,        0, 0, 4'h0, 0, 0, 0, 0, 8'h1B, 0, 1);
    // Scenario 2: (8,14),(15,15),(9,10) come back out in key order.
    add(1, 4'h4, 32'h008E0000, 0, 0, 4'h4, 1, 0, 1, 0, 8'h1B, 0, 1);
    add(1, 4'h4, 32'h00FF0000, 0, 0, 4'h4, 1, 0, 2, 0, 8'h1B, 0, 1);
    add(1, 4'h4, 32'h009A0000, 0, 0, 4'h4, 1, 0, 3, 0, 8'h1B, 0, 1);
    add(1, 4'h0, 32'h0,        1, 0, 4'h0, 0, 1, 2, 1, 8'hFF, 0, 1);
    add(1, 4'h0, 32'h0,        1, 0, 4'h0, 0, 1, 1, 1, 8'h9A, 0, 1);
    add(1, 4'h0, 32'h0,        1, 0, 4'h0, 0, 1, 0, 1, 8'h8E, 0, 1);
    add(1, 4'h0, 32'h0,        0, 0, 4'h0, 0, 0, 0, 0, 8'h8E, 0, 1);
    // Round-robin with requesters 3 and 0 contending (pointer starts at 3).
    add(1, 4'h9, 32'h55000066, 0, 0, 4'h8, 1, 0, 1, 0, 8'h8E, 0, 1);
    add(1, 4'h9, 32'h55000066, 0, 0, 4'h1, 1, 0, 2, 0, 8'h8E, 0, 1);
    add(1, 4'h9, 32'h55000066, 0, 0, 4'h8, 1, 0, 3, 0, 8'h8E, 0, 1);
    // Scenario 5: flush with 3 entries; repeated flush and deq_req ignored.
    add(1, 4'h0, 32'h0,        0, 1, 4'h0, 0, 0, 3, 0, 8'h8E, 0, 1);
    add(1, 4'hF, 32'h55000066, 1, 1, 4'h0, 0, 1, 2, 0, 8'h8E, 0, 1);
    add(1, 4'hF, 32'h55000066, 1, 0, 4'h0, 0, 1, 1, 0, 8'h8E, 0, 1);
    add(1, 4'h0, 32'h0,        0, 0, 4'h0, 0, 1, 0, 0, 8'h8E, 0, 1);
    add(1, 4'h0, 32'h0,        0, 0, 4'h0, 0, 0, 0, 0, 8'h8E, 1, 1);
    add(1, 4'h0, 32'h0,        0, 0, 4'h0, 0, 0, 0, 0, 8'h8E, 0, 1);
    // Flush of an already empty queue.
    add(1, 4'h0, 32'h0,        0, 1, 4'h0, 0, 0, 0, 0, 8'h8E, 0, 1);
    add(1, 4'h0, 32'h0,        0, 0, 4'h0, 0, 0, 0, 0, 8'h8E, 1, 1);
    add(1, 4'h0, 32'h0,        0, 0, 4'h0, 0, 0, 0, 0, 8'h8E, 0, 1);

    for (int n = 0; n < vq.size(); n++) begin
      @(negedge clk);
      drive(vq[n].rst, vq[n].rv, vq[n].kv, vq[n].dq, vq[n].fl);
      #1;
      chk($sformatf("row%0d req_ready", n), 32'(req_ready), 32'(vq[n].e_rdy));
      chk($sformatf("row%0d pq_enq", n),    32'(pq_enq),    32'(vq[n].e_enq));
      chk($sformatf("row%0d pq_deq", n),    32'(pq_deq),    32'(vq[n].e_deq));
      chk($sformatf("row%0d pq_rst", n),    32'(pq_rst),    32'(!vq[n].rst));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d count", n),      32'(count),      32'(vq[n].e_cnt));
      chk($sformatf("row%0d deq_valid", n),  32'(deq_valid),  32'(vq[n].e_dv));
      chk($sformatf("row%0d deq_kv", n),     32'(deq_kv),     32'(vq[n].e_dkv));
      chk($sformatf("row%0d flush_done", n), 32'(flush_done), 32'(vq[n].e_fd));
      chk($sformatf("row%0d deq_ready", n),  32'(deq_ready),  32'(vq[n].e_drdy));
    end

    // Scenario 4: dequeue requested on an empty queue, served after an enqueue.
    @(negedge clk);
    drive(1'b1, 4'h0, 32'h0, 1'b1, 1'b0);
    #1 chk("s4 no deq on empty", 32'(pq_deq), 32'd0);
    @(posedge clk); #1;
    chk("s4 deq_ready low", 32'(deq_ready), 32'd0);
    chk("s4 no deq_valid", 32'(deq_valid), 32'd0);
    @(negedge clk);
    drive(1'b1, 4'h4, 32'h00550000, 1'b0, 1'b0);
    #1;
    chk("s4 grant r2", 32'(req_ready), 32'h4);
    chk("s4 pq_kvi", 32'(pq_kvi), 32'h55);
    chk("s4 still no deq", 32'(pq_deq), 32'd0);
    @(posedge clk); #1;
    chk("s4 count 1", 32'(count), 32'd1);
    chk("s4 still pending", 32'(deq_ready), 32'd0);
    @(negedge clk);
    drive(1'b1, 4'h0, 32'h0, 1'b0, 1'b0);
    #1 chk("s4 pending deq issues", 32'(pq_deq), 32'd1);
    @(posedge clk); #1;
    chk("s4 deq_valid", 32'(deq_valid), 32'd1);
    chk("s4 deq_kv", 32'(deq_kv), 32'h55);
    chk("s4 deq_ready back", 32'(deq_ready), 32'd1);
    chk("s4 count 0", 32'(count), 32'd0);
    @(negedge clk); #1;
    @(posedge clk); #1;
    chk("s4 single pulse", 32'(deq_valid), 32'd0);

    // Scenario 6: reset asserted mid-flush with entries still queued.
    @(negedge clk);
    drive(1'b1, 4'h1, 32'h00000077, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    chk("s6 two entries", 32'(count), 32'd2);
    @(negedge clk);
    drive(1'b1, 4'h0, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    drive(1'b1, 4'h0, 32'h0, 1'b0, 1'b0);
    #1 chk("s6 flushing deq", 32'(pq_deq), 32'd1);
    @(posedge clk); #1;
    chk("s6 count 1", 32'(count), 32'd1);
    @(negedge clk);
    drive(1'b0, 4'hF, 32'h11223344, 1'b1, 1'b0);
    #1;
    chk("s6 pq_rst", 32'(pq_rst), 32'd1);
    chk("s6 pq_deq gated", 32'(pq_deq), 32'd0);
    chk("s6 pq_enq gated", 32'(pq_enq), 32'd0);
    chk("s6 req_ready gated", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("s6 count reset", 32'(count), 32'd0);
    chk("s6 deq_kv reset", 32'(deq_kv), 32'd0);
    chk("s6 deq_ready reset", 32'(deq_ready), 32'd1);
    @(negedge clk);
    drive(1'b1, 4'h0, 32'h0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("s6 no flush_done c%0d", c), 32'(flush_done), 32'd0);
      chk($sformatf("s6 no deq_valid c%0d", c), 32'(deq_valid), 32'd0);
    end
    // First grant after reset restarts the rotation at requester 0.
    @(negedge clk);
    drive(1'b1, 4'hF, 32'h11223344, 1'b0, 1'b0);
    #1 chk("s6 rr restart", 32'(req_ready), 32'h1);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
